// File: rtl/std_seq_mult_resp.sv
// Iterative shift-add unsigned multiplier answering a go/done handshake from the callee side.
// Optional feature: define EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module std_seq_mult_resp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Handshake: go is only looked at in S_IDLE; the edge that sees go==1 there
    // latches left/right. done is a pure decode of S_DONE and lasts one cycle,
    // during which out carries the product.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_iter;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        last_iter = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    mcand_d  = left;
                    mplier_d = right;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef EARLY_EXIT_EN
                // Nothing left to add once the shifted multiplier is empty.
                if (mplier_d == '0) begin
                    last_iter = 1'b1;
                end
`endif
                if (last_iter) begin
                    out_d   = acc_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out         = out_q;
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_std_seq_mult_resp.sv
// Bench for std_seq_mult_resp: a 32-bit and an 8-bit instance, scoreboarded products and latency checks.
// Build with EARLY_EXIT_EN defined to check the early-exit latencies instead of the fixed ones.
module tb_std_seq_mult_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go32, go8;
    logic [31:0] l32, r32, out32;
    logic [7:0]  l8, r8, out8;
    logic        done32, done8;
    logic [1:0]  dbg32, dbg8;

    int total = 0;
    int bad   = 0;
    int acc_cnt32 = 0, acc_cnt8 = 0;
    int done_cnt32 = 0, done_cnt8 = 0;
    logic [31:0] exp_q32[$];
    logic [7:0]  exp_q8[$];
    logic [31:0] mon_e32;
    logic [7:0]  mon_e8;

    always #5 clk = ~clk;

    std_seq_mult_resp #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(rst_n), .go(go32), .left(l32), .right(r32),
        .out(out32), .done(done32), .dbg_state_o(dbg32)
    );

    std_seq_mult_resp #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst_n), .go(go8), .left(l8), .right(r8),
        .out(out8), .done(done8), .dbg_state_o(dbg8)
    );

    // Scoreboards: every done pops the oldest expected product.
    always @(negedge clk) begin
        if (rst_n && done32) begin
            done_cnt32++;
            total++;
            if (exp_q32.size() == 0) begin
                bad++;
                $display("FAIL sb32_unexpected_done out=%h", out32);
            end else begin
                mon_e32 = exp_q32.pop_front();
                if (out32 !== mon_e32) begin
                    bad++;
                    $display("FAIL sb32_product got=%h exp=%h", out32, mon_e32);
                end
            end
        end
        if (rst_n && done8) begin
            done_cnt8++;
            total++;
            if (exp_q8.size() == 0) begin
                bad++;
                $display("FAIL sb8_unexpected_done out=%h", out8);
            end else begin
                mon_e8 = exp_q8.pop_front();
                if (out8 !== mon_e8) begin
                    bad++;
                    $display("FAIL sb8_product got=%h exp=%h", out8, mon_e8);
                end
            end
        end
    end

    // Expected iteration count for a given multiplier.
    function automatic int lat(input logic [31:0] r, input int w);
        int hb;
        hb = 1;
        for (int i = 0; i < w; i++) begin
            if (r[i]) hb = i + 1;
        end
`ifdef EARLY_EXIT_EN
        return hb;
`else
        return (hb > 0) ? w : w;
`endif
    endfunction

    // Starts one op at a negedge (DUT idle or in its done cycle), returns at the negedge where done shows.
    task automatic op32(input logic [31:0] l, input logic [31:0] r, input logic [31:0] e,
                        input string nm);
        int cyc;
        logic was_done;
        was_done = done32;
        go32 = 1'b1; l32 = l; r32 = r;
        exp_q32.push_back(e);
        acc_cnt32++;
        if (was_done) @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        go32 = 1'b0;
        l32 = $urandom; r32 = $urandom;
        cyc = 0;
        while (!done32 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc != lat(r, 32)) begin
            bad++;
            $display("FAIL %s_latency got=%0d exp=%0d", nm, cyc, lat(r, 32));
        end
        total++;
        if (done32 !== 1'b1 || out32 !== e) begin
            bad++;
            $display("FAIL %s_out done=%b got=%h exp=%h", nm, done32, out32, e);
        end
    endtask

    task automatic op8(input logic [7:0] l, input logic [7:0] r, input logic [7:0] e,
                       input string nm);
        int cyc;
        logic was_done;
        was_done = done8;
        go8 = 1'b1; l8 = l; r8 = r;
        exp_q8.push_back(e);
        acc_cnt8++;
        if (was_done) @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        go8 = 1'b0;
        l8 = 8'($urandom); r8 = 8'($urandom);
        cyc = 0;
        while (!done8 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc != lat({24'd0, r}, 8)) begin
            bad++;
            $display("FAIL %s_latency got=%0d exp=%0d", nm, cyc, lat({24'd0, r}, 8));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        go32 = 1'b0; l32 = '0; r32 = '0;
        go8 = 1'b0; l8 = '0; r8 = '0;
        #1;
        total++;
        if (out32 !== 32'd0 || done32 !== 1'b0 || dbg32 !== 2'd0) begin
            bad++;
            $display("FAIL reset32 out=%h done=%b state=%0d exp 0/0/0", out32, done32, dbg32);
        end
        total++;
        if (out8 !== 8'd0 || done8 !== 1'b0 || dbg8 !== 2'd0) begin
            bad++;
            $display("FAIL reset8 out=%h done=%b state=%0d exp 0/0/0", out8, done8, dbg8);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        op32(32'd3, 32'd5, 32'd15, "basic_3x5");
        @(negedge clk);
        total++;
        if (done32 !== 1'b0 || out32 !== 32'd15) begin
            bad++;
            $display("FAIL basic_pulse_width done=%b out=%h exp done=0 out=f", done32, out32);
        end
        repeat (3) @(negedge clk);
        total++;
        if (out32 !== 32'd15 || done32 !== 1'b0) begin
            bad++;
            $display("FAIL basic_out_hold out=%h done=%b exp out=f done=0", out32, done32);
        end
    endtask

    task automatic test_wrap();
        op32(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "wrap_ff_x2");
        op32(32'h0001_0000, 32'h0001_0000, 32'd0, "wrap_2p16sq");
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        go32 = 1'b1; l32 = 32'd6; r32 = 32'd7;
        exp_q32.push_back(32'd42);
        acc_cnt32++;
        @(posedge clk);
        @(negedge clk);
        l32 = 32'd9; r32 = 32'd9;
        exp_q32.push_back(32'd81);
        acc_cnt32++;
        cyc = 0;
        while (!done32 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc != lat(32'd7, 32) || out32 !== 32'd42) begin
            bad++;
            $display("FAIL b2b_first cyc=%0d out=%h exp cyc=%0d out=2a", cyc, out32, lat(32'd7, 32));
        end
        @(negedge clk);
        total++;
        if (done32 !== 1'b0 || dbg32 !== 2'd0) begin
            bad++;
            $display("FAIL b2b_idle_gap done=%b state=%0d exp 0/0", done32, dbg32);
        end
        @(posedge clk);
        @(negedge clk);
        go32 = 1'b0;
        cyc = 0;
        while (!done32 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc != lat(32'd9, 32) || out32 !== 32'd81) begin
            bad++;
            $display("FAIL b2b_second cyc=%0d out=%h exp cyc=%0d out=51", cyc, out32, lat(32'd9, 32));
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        @(negedge clk);
        go32 = 1'b1; l32 = 32'd123; r32 = 32'd456;
        @(posedge clk);
        @(negedge clk);
        go32 = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (done32 !== 1'b0 || out32 !== 32'd0 || dbg32 !== 2'd0) begin
            bad++;
            $display("FAIL midreset_clear done=%b out=%h state=%0d exp 0/0/0", done32, out32, dbg32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL midreset_no_done got=%0d pulses exp=0", n);
        end
    endtask

    task automatic test_early_exit();
        op32(32'd7, 32'd1, 32'd7, "ee_7x1");
        op32(32'd7, 32'h8000_0000, 32'h8000_0000, "ee_7x2p31");
        op32(32'd5, 32'd0, 32'd0, "ee_5x0");
        @(negedge clk);
        op8(8'd7, 8'd1, 8'd7, "ee8_7x1");
        op8(8'd5, 8'd0, 8'd0, "ee8_5x0");
        op8(8'hFF, 8'hFF, 8'h01, "ee8_ffxff");
    endtask

    task automatic test_random();
        logic [31:0] a, b, p;
        logic [7:0]  a8, b8, p8;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            p = a * b;
            op32(a, b, p, "rand32");
        end
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            p8 = a8 * b8;
            op8(a8, b8, p8, "rand8");
        end
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt32 != acc_cnt32 || exp_q32.size() != 0) begin
            bad++;
            $display("FAIL count32 dones=%0d accepts=%0d pending=%0d", done_cnt32, acc_cnt32, exp_q32.size());
        end
        total++;
        if (done_cnt8 != acc_cnt8 || exp_q8.size() != 0) begin
            bad++;
            $display("FAIL count8 dones=%0d accepts=%0d pending=%0d", done_cnt8, acc_cnt8, exp_q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_reset_mid_op();
        test_early_exit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
